// File: rtl/aes_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl_if
// Bundles every signal the round sequencer exchanges with its surroundings,
// apart from clock and reset.
//   Input handshake : IN_VALID, IN_READY, IN, MODE_256
//   Key table       : RK_IDX (request), RK, RK_VALID
//   Round datapath  : RND_STATE, RND_LAST (to datapath), RND_RESULT (back)
//   Output handshake: OUT_VALID, OUT_READY, OUT
//   Status          : BUSY, ROUND_CNT
// Modports: slave = the controller, master = the environment driving it.
// ---------------------------------------------------------------------------
interface aes_round_ctrl_if #(
    parameter int BLOCK_LENGTH = 128
);
    logic                    IN_VALID;
    logic                    IN_READY;
    logic [BLOCK_LENGTH-1:0] IN;
    logic                    MODE_256;
    logic [3:0]              RK_IDX;
    logic [BLOCK_LENGTH-1:0] RK;
    logic                    RK_VALID;
    logic [BLOCK_LENGTH-1:0] RND_STATE;
    logic                    RND_LAST;
    logic [BLOCK_LENGTH-1:0] RND_RESULT;
    logic                    OUT_VALID;
    logic                    OUT_READY;
    logic [BLOCK_LENGTH-1:0] OUT;
    logic                    BUSY;
    logic [3:0]              ROUND_CNT;

    modport slave (
        input  IN_VALID, IN, MODE_256, RK, RK_VALID, RND_RESULT, OUT_READY,
        output IN_READY, RK_IDX, RND_STATE, RND_LAST, OUT_VALID, OUT, BUSY, ROUND_CNT
    );

    modport master (
        output IN_VALID, IN, MODE_256, RK, RK_VALID, RND_RESULT, OUT_READY,
        input  IN_READY, RK_IDX, RND_STATE, RND_LAST, OUT_VALID, OUT, BUSY, ROUND_CNT
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
// Iterative AES encryption round sequencer. Accepts a plaintext block, applies
// the initial AddRoundKey, then steps a shared combinational round datapath
// once per cycle (10 rounds for AES-128, 14 for AES-256) and presents the
// ciphertext until the consumer takes it.
// Ports:
//   CLK  - clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - aes_round_ctrl_if.slave: input/output handshakes, key table
//          request/response, round datapath drive/result, BUSY, ROUND_CNT
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int BLOCK_LENGTH = 128
) (
    input  logic              CLK,
    input  logic              RST,
    aes_round_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [BLOCK_LENGTH-1:0] st_reg, st_nxt;
    logic [3:0]              round, round_nxt;
    logic [3:0]              nr, nr_nxt;

    logic                    in_ready;
    logic                    out_valid;
    logic                    rnd_last;
    logic [3:0]              rk_idx;
    logic                    at_last;

    assign at_last = (round == nr);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            st_reg <= '0;
            round  <= '0;
            nr     <= 4'd10;
        end else begin
            state  <= state_nxt;
            st_reg <= st_nxt;
            round  <= round_nxt;
            nr     <= nr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        st_nxt    = st_reg;
        round_nxt = round;
        nr_nxt    = nr;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rnd_last  = 1'b0;
        rk_idx    = 4'd0;

        unique case (state)
            IDLE: begin
                // Key 0 is presented here so the initial AddRoundKey lands
                // together with the load.
                in_ready = bus.RK_VALID;
                if (bus.IN_VALID && bus.RK_VALID) begin
                    st_nxt    = bus.IN ^ bus.RK;
                    nr_nxt    = bus.MODE_256 ? 4'd14 : 4'd10;
                    round_nxt = 4'd1;
                    state_nxt = ROUND;
                end
            end

            ROUND: begin
                rk_idx   = round;
                rnd_last = at_last;
                // A missing key freezes everything; nothing advances.
                if (bus.RK_VALID) begin
                    st_nxt = bus.RND_RESULT;
                    if (at_last) begin
                        state_nxt = DONE;
                    end else begin
                        round_nxt = round + 4'd1;
                    end
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (bus.OUT_READY) begin
                    state_nxt = IDLE;
                    round_nxt = 4'd0;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.IN_READY  = in_ready;
    assign bus.RK_IDX    = rk_idx;
    assign bus.RND_STATE = st_reg;
    assign bus.RND_LAST  = rnd_last;
    assign bus.OUT_VALID = out_valid;
    assign bus.OUT       = st_reg;
    assign bus.BUSY      = (state != IDLE);
    assign bus.ROUND_CNT = round;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
// Drives aes_round_ctrl through its interface. The bench provides the key
// table and the combinational round datapath, and keeps its own AES model
// (key schedule + full encryption) to predict ciphertexts and intermediate
// states.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    typedef logic [127:0] rk_arr_t [16];

    typedef struct {
        logic [127:0] pt;
        logic [255:0] key;
        logic         mode;
        logic [127:0] ct;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    aes_round_ctrl_if #(.BLOCK_LENGTH(128)) bus ();

    aes_round_ctrl #(.BLOCK_LENGTH(128)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_t [256];
    rk_arr_t      rk_tab;
    logic [127:0] rnd_result;
    vec_t         vecs [5];

    // ---------------- AES model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic void gen_sbox();
        logic [7:0] inv;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (b != 0 && gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
            sbox_t[b] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic void expand_key(input logic [255:0] key, input logic mode,
                                       output rk_arr_t rks);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nrr;
        nk  = mode ? 8 : 4;
        nrr = mode ? 14 : 10;
        rc  = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = 32'h0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nrr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rks[r] = (r <= nrr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endfunction

    // Byte k of a block is bits [127-8k -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) a[i] = sbox_t[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = a[4*((c+r)%4)+r];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a[0] = b[4*c]; a[1] = b[4*c+1]; a[2] = b[4*c+2]; a[3] = b[4*c+3];
                b[4*c]   = gmul(a[0], 8'h02) ^ gmul(a[1], 8'h03) ^ a[2] ^ a[3];
                b[4*c+1] = a[0] ^ gmul(a[1], 8'h02) ^ gmul(a[2], 8'h03) ^ a[3];
                b[4*c+2] = a[0] ^ a[1] ^ gmul(a[2], 8'h02) ^ gmul(a[3], 8'h03);
                b[4*c+3] = gmul(a[0], 8'h03) ^ a[1] ^ a[2] ^ gmul(a[3], 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                                 input logic mode);
        rk_arr_t rks;
        logic [127:0] s;
        int nrr;
        nrr = mode ? 14 : 10;
        expand_key(key, mode, rks);
        s = pt ^ rks[0];
        for (int r = 1; r <= nrr; r++) s = aes_round(s, rks[r], r == nrr);
        return s;
    endfunction

    // ---------------- environment: key table + round datapath ----------------
    assign bus.RK         = rk_tab[bus.RK_IDX];
    assign bus.RND_RESULT = rnd_result;

    // Evaluated mid-cycle from values that changed at the previous rising edge.
    always @(negedge clk) rnd_result <= aes_round(bus.RND_STATE, bus.RK, bus.RND_LAST);

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {ROUND_CNT, RK_IDX, RND_LAST, OUT_VALID, IN_READY, BUSY}
    function automatic logic [127:0] status();
        return {116'h0, bus.ROUND_CNT, bus.RK_IDX, bus.RND_LAST, bus.OUT_VALID,
                bus.IN_READY, bus.BUSY};
    endfunction

    function automatic logic [127:0] st_exp(input logic [3:0] rc, input logic [3:0] idx,
                                            input logic last, input logic ov,
                                            input logic ir, input logic busy);
        return {116'h0, rc, idx, last, ov, ir, busy};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block from IDLE back to IDLE. rk_tab must already hold the key.
    // RK_VALID is dropped for stall_len edges while round stall_at is current;
    // OUT_READY is held low for bp_len cycles in DONE.
    task automatic run_block(input logic [127:0] pt, input logic mode, input logic [127:0] ct,
                             input int unsigned stall_at, input int unsigned stall_len,
                             input int unsigned bp_len);
        int unsigned  nrr, done_r, stalls;
        logic [127:0] exp_st;
        nrr = mode ? 14 : 10;
        bus.IN = pt; bus.MODE_256 = mode; bus.IN_VALID = 1'b1;
        bus.RK_VALID = 1'b1; bus.OUT_READY = 1'b0;
        #1;
        check("idle_status", status(), st_exp(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        // Inputs after the handshake must be ignored.
        bus.IN_VALID = 1'b0; bus.IN = rnd128(); bus.MODE_256 = ~mode;
        exp_st = pt ^ rk_tab[0];
        done_r = 0; stalls = 0;
        while (done_r < nrr) begin
            check("round_status", status(),
                  st_exp(4'(done_r+1), 4'(done_r+1), (done_r+1 == nrr), 1'b0, 1'b0, 1'b1));
            check("round_state", bus.RND_STATE, exp_st);
            if (done_r+1 == stall_at && stalls < stall_len) begin
                bus.RK_VALID = 1'b0;
                stalls++;
            end else begin
                bus.RK_VALID = 1'b1;
            end
            tick();
            if (bus.RK_VALID) begin
                exp_st = aes_round(exp_st, rk_tab[done_r+1], done_r+1 == nrr);
                done_r++;
            end
        end
        bus.RK_VALID = 1'b1;
        check("done_status", status(), st_exp(4'(nrr), 4'd0, 1'b0, 1'b1, 1'b0, 1'b1));
        check("ciphertext", bus.OUT, ct);
        for (int unsigned i = 0; i < bp_len; i++) begin
            bus.IN_VALID = 1'b1; bus.IN = rnd128();
            tick();
            check("bp_status", status(), st_exp(4'(nrr), 4'd0, 1'b0, 1'b1, 1'b0, 1'b1));
            check("bp_out", bus.OUT, ct);
        end
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
        tick();
        bus.OUT_READY = 1'b0;
        check("release_status", status(), st_exp(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
    endtask

    // ---------------- test ----------------
    initial begin
        int acc_n, outs, acc0, acc1;
        logic drop_pending;
        logic [255:0] key;
        logic [127:0] pt;
        logic         mode;
        int unsigned  nrr;

        gen_sbox();

        vecs[0] = '{pt: 128'h00112233445566778899aabbccddeeff,
                    key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, mode: 1'b0,
                    ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff,
                    key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    mode: 1'b1, ct: 128'h8ea2b7ca516745bfeafc49904b496089};
        vecs[2] = '{pt: 128'h3243f6a8885a308d313198a2e0370734,
                    key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, mode: 1'b0,
                    ct: 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[3] = '{pt: 128'h6bc1bee22e409f96e93d7e117393172a,
                    key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, mode: 1'b0,
                    ct: 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[4] = '{pt: 128'h6bc1bee22e409f96e93d7e117393172a,
                    key: 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4,
                    mode: 1'b1, ct: 128'hf3eed1bdb5d2a03c064b5a7e3db181f8};

        rst = 1'b1;
        bus.IN_VALID = 1'b0; bus.IN = '0; bus.MODE_256 = 1'b0;
        bus.RK_VALID = 1'b0; bus.OUT_READY = 1'b0;
        expand_key(vecs[0].key, 1'b0, rk_tab);
        repeat (3) tick();

        // Reset state, IN_READY follows RK_VALID even in reset.
        check("rst_status_rkv0", status(), st_exp(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        check("rst_out", bus.OUT, 128'h0);
        check("rst_rnd_state", bus.RND_STATE, 128'h0);
        bus.RK_VALID = 1'b1;
        #1;
        check("rst_status_rkv1", status(), st_exp(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        rst = 1'b0;
        tick();

        // Known-answer table.
        for (int v = 0; v < 5; v++) begin
            expand_key(vecs[v].key, vecs[v].mode, rk_tab);
            run_block(vecs[v].pt, vecs[v].mode, vecs[v].ct, 0, 0, 0);
        end

        // Backpressure: 5 cycles in DONE.
        expand_key(vecs[0].key, 1'b0, rk_tab);
        run_block(vecs[0].pt, 1'b0, vecs[0].ct, 0, 0, 5);

        // Key stall: 3 cycles at round 4.
        run_block(vecs[0].pt, 1'b0, vecs[0].ct, 4, 3, 0);

        // No key in IDLE: no accept.
        bus.RK_VALID = 1'b0; bus.IN_VALID = 1'b1; bus.IN = vecs[0].pt;
        #1;
        check("nokey_ready", status(), st_exp(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        repeat (3) tick();
        check("nokey_idle", status(), st_exp(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        bus.IN_VALID = 1'b0; bus.RK_VALID = 1'b1;

        // Reset at round 6, then a clean block.
        bus.IN = vecs[0].pt; bus.MODE_256 = 1'b0; bus.IN_VALID = 1'b1;
        tick();
        bus.IN_VALID = 1'b0;
        repeat (5) tick();
        check("pre_rst_round6", status(), st_exp(4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_status", status(), st_exp(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        check("mid_rst_out", bus.OUT, 128'h0);
        run_block(vecs[0].pt, 1'b0, vecs[0].ct, 0, 0, 0);

        // Back-to-back with IN_VALID held and OUT_READY high.
        bus.IN = vecs[0].pt; bus.MODE_256 = 1'b0; bus.IN_VALID = 1'b1;
        bus.RK_VALID = 1'b1; bus.OUT_READY = 1'b1;
        #1;
        acc_n = 0; outs = 0; acc0 = 0; acc1 = 0; drop_pending = 1'b0;
        for (int cyc = 0; cyc < 60 && outs < 2; cyc++) begin
            if (bus.IN_VALID && bus.IN_READY) begin
                if (acc_n == 0) acc0 = cyc; else acc1 = cyc;
                acc_n++;
                drop_pending = (acc_n == 2);
            end
            if (bus.OUT_VALID) begin
                check("b2b_ct", bus.OUT, vecs[0].ct);
                outs++;
            end
            tick();
            if (drop_pending) begin
                bus.IN_VALID = 1'b0;
                drop_pending = 1'b0;
            end
        end
        bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
        check("b2b_outs", 128'(outs), 128'd2);
        check("b2b_gap", 128'(acc1 - acc0), 128'd12);
        check("b2b_idle", status(), st_exp(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));

        // Randomized blocks against the reference model.
        for (int n = 0; n < 25; n++) begin
            key  = {rnd128(), rnd128()};
            mode = 1'($urandom_range(0, 1));
            pt   = rnd128();
            nrr  = mode ? 14 : 10;
            expand_key(key, mode, rk_tab);
            run_block(pt, mode, aes_encrypt(pt, key, mode),
                      $urandom_range(1, nrr), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
